rst_seq_wdog: RTL and testbench

- Parametrised reset sequencer and simulation watchdog; successor to the fixed clock/reset generator.
- Takes the raw clock and asynchronous reset, and produces a synchronised, stretched reset for the DUT.
- Counts run cycles and enforces a cycle-count timeout.
- Latches per-channel error flags and counts error cycles, with an optional halt-on-first-error mode.
- Synthesizable; instantiated at the top of each demo testbench, between the stimulus clock source and the processor.

---
 rtl/rst_seq_wdog.sv | 99 +++++++++
 tb/tb_rst_seq_wdog.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_wdog.sv
// Reset sequencer and run watchdog: synchronises and stretches reset, counts run cycles, latches errors.
// rst_out releases on the (SYNC_STAGES+RST_CYCLES)-th edge after rst falls; no backpressure.
module rst_seq_wdog #(
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 2,
  parameter int CNT_WIDTH   = 32,
  parameter int TIMEOUT     = 100000,
  parameter int NUM_ERR     = 1,
  parameter int ERR_MODE    = 0,
  parameter int ECNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_ERR-1:0]    err,
  output logic                  rst_out,
  output logic                  running,
  output logic                  halted,
  output logic                  timeout,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [NUM_ERR-1:0]    err_sticky,
  output logic [ECNT_WIDTH-1:0] err_count
);

  typedef enum logic [1:0] {SYNC, STRETCH, RUN, HALT} state_t;

  localparam int SW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_WIDTH:0] TO_LIM = (CNT_WIDTH+1)'(TIMEOUT);

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic [SW-1:0]           str_q, str_d;
  logic [CNT_WIDTH-1:0]    cnt_d, cnt_inc;
  logic [NUM_ERR-1:0]      stk_d;
  logic [ECNT_WIDTH-1:0]   ecnt_d, ecnt_inc;
  logic                    to_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SYNC;
      sync_q      <= '1;
      str_q       <= '0;
      cycle_count <= '0;
      err_sticky  <= '0;
      err_count   <= '0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], 1'b0};
      str_q       <= str_d;
      cycle_count <= cnt_d;
      err_sticky  <= stk_d;
      err_count   <= ecnt_d;
      timeout     <= to_d;
    end
  end

  assign cnt_inc  = (cycle_count == '1) ? cycle_count : cycle_count + 1'b1;
  assign ecnt_inc = (err_count == '1) ? err_count : err_count + 1'b1;

  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    cnt_d   = cycle_count;
    stk_d   = err_sticky;
    ecnt_d  = err_count;
    to_d    = timeout;
    case (state_q)
      // Leave SYNC on the edge that loads 0 into the last synchroniser stage.
      SYNC: begin
        if (!sync_q[SYNC_STAGES-2]) state_d = STRETCH;
      end
      STRETCH: begin
        if (str_q == SW'(RST_CYCLES-1)) state_d = RUN;
        else                            str_d   = str_q + SW'(1);
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (|err) begin
          stk_d  = err_sticky | err;
          ecnt_d = ecnt_inc;
          if (ERR_MODE == 1) state_d = HALT;
        end
        if (TIMEOUT != 0 && {1'b0, cnt_inc} == TO_LIM) begin
          to_d    = 1'b1;
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
    endcase
  end

  // The last synchroniser stage also holds reset so release can never precede it.
  assign rst_out = sync_q[SYNC_STAGES-1] | (state_q == SYNC) | (state_q == STRETCH);
  assign running = (state_q == RUN);
  assign halted  = (state_q == HALT);

endmodule

// File: tb/tb_rst_seq_wdog.sv
// Five differently parametrised instances, each checked every cycle against a cycle-level behavioural model.
module tb_rst_seq_wdog;

  localparam int     PS[5]    = '{2, 2, 2, 2, 3};
  localparam int     PR[5]    = '{2, 2, 2, 2, 1};
  localparam int     PTO[5]   = '{0, 10, 0, 5, 0};
  localparam int     PMODE[5] = '{0, 0, 1, 0, 0};
  localparam longint PCMAX[5] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 7};
  localparam int     PEMAX[5] = '{65535, 65535, 65535, 65535, 3};
  localparam logic [2:0] PM[5] = '{3'b111, 3'b001, 3'b001, 3'b011, 3'b001};

  logic       clk;
  logic [4:0] rstv;
  logic [2:0] errv [5];
  logic       ro [5];
  logic       rn [5];
  logic       hl [5];
  logic       tov [5];
  logic [31:0] cc [5];
  logic [15:0] ec [5];
  logic [2:0]  st [5];

  logic [31:0] cc0, cc1, cc2, cc3;
  logic [2:0]  cc4;
  logic [15:0] ec0, ec1, ec2, ec3;
  logic [1:0]  ec4;
  logic [2:0]  st0;
  logic        st1, st2, st4;
  logic [1:0]  st3;

  assign cc[0] = cc0;  assign cc[1] = cc1;  assign cc[2] = cc2;  assign cc[3] = cc3;  assign cc[4] = {29'd0, cc4};
  assign ec[0] = ec0;  assign ec[1] = ec1;  assign ec[2] = ec2;  assign ec[3] = ec3;  assign ec[4] = {14'd0, ec4};
  assign st[0] = st0;  assign st[1] = {2'd0, st1}; assign st[2] = {2'd0, st2};
  assign st[3] = {1'b0, st3}; assign st[4] = {2'd0, st4};

  rst_seq_wdog #(.NUM_ERR(3), .TIMEOUT(0)) u0 (
    .clk(clk), .rst(rstv[0]), .err(errv[0]), .rst_out(ro[0]), .running(rn[0]), .halted(hl[0]),
    .timeout(tov[0]), .cycle_count(cc0), .err_sticky(st0), .err_count(ec0));
  rst_seq_wdog #(.TIMEOUT(10)) u1 (
    .clk(clk), .rst(rstv[1]), .err(errv[1][0]), .rst_out(ro[1]), .running(rn[1]), .halted(hl[1]),
    .timeout(tov[1]), .cycle_count(cc1), .err_sticky(st1), .err_count(ec1));
  rst_seq_wdog #(.TIMEOUT(0), .ERR_MODE(1)) u2 (
    .clk(clk), .rst(rstv[2]), .err(errv[2][0]), .rst_out(ro[2]), .running(rn[2]), .halted(hl[2]),
    .timeout(tov[2]), .cycle_count(cc2), .err_sticky(st2), .err_count(ec2));
  rst_seq_wdog #(.TIMEOUT(5), .NUM_ERR(2)) u3 (
    .clk(clk), .rst(rstv[3]), .err(errv[3][1:0]), .rst_out(ro[3]), .running(rn[3]), .halted(hl[3]),
    .timeout(tov[3]), .cycle_count(cc3), .err_sticky(st3), .err_count(ec3));
  rst_seq_wdog #(.SYNC_STAGES(3), .RST_CYCLES(1), .CNT_WIDTH(3), .TIMEOUT(0), .ECNT_WIDTH(2)) u4 (
    .clk(clk), .rst(rstv[4]), .err(errv[4][0]), .rst_out(ro[4]), .running(rn[4]), .halted(hl[4]),
    .timeout(tov[4]), .cycle_count(cc4), .err_sticky(st4), .err_count(ec4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: edges since reset release, run cycles, halt/timeout flags, error record.
  int         m_edges [5];
  longint     m_cyc [5];
  bit         m_halt [5];
  bit         m_to [5];
  logic [2:0] m_stk [5];
  longint     m_ecnt [5];
  int         total, bad;
  int         phase;

  task automatic model_reset(input int i);
    m_edges[i] = 0; m_cyc[i] = 0; m_halt[i] = 0; m_to[i] = 0; m_stk[i] = 3'd0; m_ecnt[i] = 0;
  endtask

  function automatic bit exp_run(input int i);
    return (m_edges[i] >= PS[i] + PR[i]) && !m_halt[i];
  endfunction

  task automatic model_edge(input int i);
    logic [2:0] e;
    e = errv[i] & PM[i];
    if (rstv[i]) model_reset(i);
    else begin
      if (m_edges[i] < 1000) m_edges[i]++;
      if (m_edges[i] > PS[i] + PR[i] && !m_halt[i]) begin
        if (m_cyc[i] < PCMAX[i]) m_cyc[i]++;
        if (e != 3'd0) begin
          m_stk[i] |= e;
          if (m_ecnt[i] < PEMAX[i]) m_ecnt[i]++;
          if (PMODE[i] == 1) m_halt[i] = 1;
        end
        if (PTO[i] != 0 && m_cyc[i] == longint'(PTO[i])) begin
          m_halt[i] = 1;
          m_to[i]   = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("u%0d.rst_out", i), longint'(ro[i]), longint'(m_edges[i] < PS[i] + PR[i]));
      chk($sformatf("u%0d.running", i), longint'(rn[i]), longint'(exp_run(i)));
      chk($sformatf("u%0d.halted", i), longint'(hl[i]), longint'(m_halt[i]));
      chk($sformatf("u%0d.timeout", i), longint'(tov[i]), longint'(m_to[i]));
      chk($sformatf("u%0d.cycle_count", i), longint'(cc[i]), m_cyc[i]);
      chk($sformatf("u%0d.err_sticky", i), longint'(st[i]), longint'(m_stk[i]));
      chk($sformatf("u%0d.err_count", i), longint'(ec[i]), m_ecnt[i]);
    end
  endtask

  task automatic drive_errs();
    errv[0] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    errv[1] = ($urandom_range(0, 9) < 3) ? 3'd1 : 3'd0;
    if (exp_run(2)) errv[2] = (m_cyc[2] == 6 || phase != 0) ? 3'd1 : 3'd0;
    else            errv[2] = 3'($urandom_range(0, 1));
    if (exp_run(3)) errv[3] = (m_cyc[3] == 4) ? (3'd1 | 3'($urandom_range(0, 3))) : 3'd0;
    else            errv[3] = 3'($urandom_range(0, 3));
    errv[4] = (phase == 0) ? 3'd1 : 3'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 5; i++) model_edge(i);
    #1;
    check_all();
    drive_errs();
  endtask

  initial begin
    int n;
    total = 0; bad = 0; phase = 0;
    rstv = 5'h1f;
    for (int i = 0; i < 5; i++) begin errv[i] = 3'd0; model_reset(i); end
    #1;
    check_all();
    repeat (3) tick();
    rstv = 5'h00;

    // Release of all instances; every one reaches its halt/saturation point.
    repeat (40) tick();
    chk("u1.halt_at_10", longint'(cc[1]), 10);
    chk("u1.timeout_set", longint'(tov[1]), 1);
    chk("u2.halt_cycle", longint'(cc[2]), 7);
    chk("u2.halt_ecnt", longint'(ec[2]), 1);
    chk("u3.collision_to", longint'(tov[3]), 1);
    chk("u3.collision_ecnt", longint'(ec[3]), 1);
    chk("u4.ecnt_sat", longint'(ec[4]), 3);
    chk("u4.cycle_sat", longint'(cc[4]), 7);
    phase = 1;

    // Asynchronous reset of u0 between edges once it has completed 50 run cycles.
    n = 0;
    while (m_cyc[0] != 50 && n < 100) begin tick(); n++; end
    chk("u0.reach_50", m_cyc[0], 50);
    #3;
    rstv[0] = 1'b1;
    model_reset(0);
    #1;
    check_all();
    chk("u0.async_rst_out", longint'(ro[0]), 1);
    chk("u0.async_cycle_count", longint'(cc[0]), 0);
    repeat (2) tick();
    rstv[0] = 1'b0;
    repeat (3) tick();

    // Reset glitch while u0 is stretching: sequencing starts over.
    #2;
    rstv[0] = 1'b1;
    model_reset(0);
    #1;
    check_all();
    #1;
    rstv[0] = 1'b0;
    repeat (30) tick();

    // Only reset leaves HALT; rerun every instance with random errors.
    #2;
    rstv = 5'h1f;
    for (int i = 0; i < 5; i++) model_reset(i);
    #1;
    check_all();
    repeat (2) tick();
    rstv = 5'h00;
    repeat (25) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
